psa_search_ctrl: RTL and testbench
==================================

Name: psa_search_ctrl

Overview:
Sequencer for the pattern search accelerator. It drives the single-port block RAM (8-bit address, 8-bit data, registered read) through a naive sliding-window byte search of a configurable address block. It reports the absolute address of the first match and can resume from the match to find later occurrences. It sits between the top-level control inputs and the BRAM port, and owns all BRAM read traffic during a search.

Parameters:
ADDR_W, 8, BRAM address width.
DATA_W, 8, BRAM data width (one pattern byte).
MAX_PAT, 4, maximum pattern length in bytes.
RD_LAT, 1, BRAM read latency in cycles (must be >=1).

Ports:
CLK100MHZ  in  1  system clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  1-cycle pulse; latches the config and begins a search at offset 0.
resume  in  1  1-cycle pulse; continues the search from the last match offset + 1.
blk_base  in  ADDR_W  first BRAM address of the block to search.
blk_len  in  ADDR_W+1  block length in bytes, 0..2^ADDR_W.
pattern  in  MAX_PAT*DATA_W  pattern bytes; byte 0 in the LSBs.
pat_len  in  $clog2(MAX_PAT)+1  pattern length in bytes.
mem_en  out  1  BRAM enable.
mem_addr  out  ADDR_W  BRAM read address.
mem_rdata  in  DATA_W  BRAM read data.
busy  out  1  search in progress.
done  out  1  search finished; held until the next accepted start or resume.
found  out  1  match found; valid while done=1.
match_addr  out  ADDR_W  absolute address of the match start; valid while done=1 and found=1.
err  out  1  invalid config; valid while done=1.

Behaviour:
- Reset (async, reset=0): state=IDLE. busy, done, found, err, mem_en = 0. mem_addr, match_addr = 0. Internal offsets i, j = 0. Reset mid-search aborts immediately; no partial result is kept.
- Config latch: on an accepted start, latch blk_base, blk_len, pattern and pat_len. Inputs may change afterwards without effect.
- States: IDLE, ISSUE, WAIT, CMP, DONE.
- IDLE/DONE + start:
  - If pat_len==0, pat_len>MAX_PAT, or pat_len>blk_len, go to DONE with err=1, found=0. mem_en is never asserted.
  - Otherwise set i=0, j=0, clear done/found/err, and go to ISSUE.
- DONE + resume, with found=1 and err=0: i=i+1, j=0, clear done/found, go to ISSUE. Resume is ignored in any other state or condition.
- start and resume in the same cycle: start wins. Both are ignored while busy.
- ISSUE: mem_en=1, mem_addr=(base+i+j) mod 2^ADDR_W, so addresses wrap past the top of memory.
  - If RD_LAT==1, next state is CMP; otherwise WAIT.
- WAIT: holds RD_LAT-1 cycles (counter), then goes to CMP. mem_en=0.
- CMP: compare mem_rdata with pattern byte j.
  - Match, j<pat_len-1: j=j+1, go to ISSUE.
  - Match, j==pat_len-1: found=1, match_addr=base+i (mod 2^ADDR_W), go to DONE.
  - Mismatch, i<blk_len-pat_len: i=i+1, j=0, go to ISSUE.
  - Mismatch, i==blk_len-pat_len: found=0, go to DONE.
- Resume past the last candidate (i+1 > blk_len-pat_len): go directly to DONE with found=0 next cycle, no reads.
- busy=1 exactly in ISSUE/WAIT/CMP. done=1 exactly in DONE.
- Timing: each byte compare costs RD_LAT+1 cycles. busy rises the cycle after start is sampled. done rises the cycle after the final CMP.
- Arithmetic: i and j are ADDR_W+1 bits wide. Comparisons are unsigned. The address sum is truncated to ADDR_W bits.

Test Plan:
Setup for all scenarios: BRAM model with RD_LAT=1. mem[0..9]=11,22,33,22,33,44,22,33,44,55; mem[254]=0x01, mem[255]=0xAA, all other addresses 0x00 (so mem[0]=0x11 in scenario 4).
1. start, base=0, blk_len=10, pattern={22,33,44}, pat_len=3 -> 8 byte compares; busy high exactly 16 cycles; done=1, found=1, match_addr=3, err=0.
2. resume after scenario 1 -> candidates 4, 5, 6 checked; done=1, found=1, match_addr=6; busy high 10 cycles.
3. resume after scenario 2 -> candidate 7 mismatches (last candidate) -> done=1, found=0. A further resume -> ignored, outputs unchanged.
4. start, base=254, blk_len=4, pattern={0xAA,0x11}, pat_len=2 -> mem_addr sequence 254, 255, 0 -> found=1, match_addr=255.
5. start with pat_len=0, and separately pat_len=4 with blk_len=3 -> done=1, err=1, found=0 the cycle after start; mem_en stays 0 throughout.
6. Drive reset=0 mid-scenario 1 -> busy, done, found, err and mem_en go to 0 immediately, without waiting for a clock edge. Release reset, then start -> scenario 1 result is reproduced exactly.

Source files
------------

// File: rtl/psa_search_ctrl.sv
// Sequencer for the pattern search accelerator: naive sliding-window byte search over a
// BRAM block, reporting the first match address and resuming from it on request.
module psa_search_ctrl #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int MAX_PAT = 4,
   parameter int RD_LAT  = 1
) (
   input  logic                      CLK100MHZ,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      resume,
   input  logic [ADDR_W-1:0]         blk_base,
   input  logic [ADDR_W:0]           blk_len,
   input  logic [MAX_PAT*DATA_W-1:0] pattern,
   input  logic [$clog2(MAX_PAT):0]  pat_len,
   output logic                      mem_en,
   output logic [ADDR_W-1:0]         mem_addr,
   input  logic [DATA_W-1:0]         mem_rdata,
   output logic                      busy,
   output logic                      done,
   output logic                      found,
   output logic [ADDR_W-1:0]         match_addr,
   output logic                      err
);
   localparam int CW  = ADDR_W + 1;
   localparam int PLW = $clog2(MAX_PAT) + 1;
   localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CMP, DONE} state_t;
   state_t state;

   logic [ADDR_W-1:0]         base_q;
   logic [CW-1:0]             len_q;
   logic [MAX_PAT*DATA_W-1:0] pat_q;
   logic [PLW-1:0]            plen_q;
   logic [CW-1:0]             i;
   logic [CW-1:0]             j;
   logic [WCW-1:0]            wcnt;

   logic [CW-1:0]     plen_ext;
   logic [CW-1:0]     last_i;
   logic [CW-1:0]     i_nxt;
   logic [CW-1:0]     j_nxt;
   logic [DATA_W-1:0] pat_byte;
   logic              hit;
   logic              cfg_bad;

   function automatic logic [ADDR_W-1:0] addr_of(input logic [ADDR_W-1:0] b,
                                                 input logic [CW-1:0] ii,
                                                 input logic [CW-1:0] jj);
      return b + ii[ADDR_W-1:0] + jj[ADDR_W-1:0];
   endfunction

   always_comb begin
      plen_ext = CW'(plen_q);
      last_i   = len_q - plen_ext;
      i_nxt    = i + CW'(1);
      j_nxt    = j + CW'(1);
      pat_byte = '0;
      for (int k = 0; k < MAX_PAT; k++) begin
         if (j == CW'(k)) pat_byte = pat_q[k*DATA_W +: DATA_W];
      end
      hit     = (mem_rdata == pat_byte);
      cfg_bad = (pat_len == '0) || (pat_len > PLW'(MAX_PAT)) || (CW'(pat_len) > blk_len);
   end

   always_ff @(posedge CLK100MHZ or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         found      <= 1'b0;
         err        <= 1'b0;
         mem_en     <= 1'b0;
         mem_addr   <= '0;
         match_addr <= '0;
         base_q     <= '0;
         len_q      <= '0;
         pat_q      <= '0;
         plen_q     <= '0;
         i          <= '0;
         j          <= '0;
         wcnt       <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  base_q <= blk_base;
                  len_q  <= blk_len;
                  pat_q  <= pattern;
                  plen_q <= pat_len;
                  i      <= '0;
                  j      <= '0;
                  found  <= 1'b0;
                  if (cfg_bad) begin
                     state <= DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else begin
                     state    <= ISSUE;
                     done     <= 1'b0;
                     err      <= 1'b0;
                     busy     <= 1'b1;
                     mem_en   <= 1'b1;
                     mem_addr <= blk_base;
                  end
               end else if (resume && state == DONE && found && !err) begin
                  found <= 1'b0;
                  // With no candidate window left, report "no further match" without any reads.
                  if (i_nxt <= last_i) begin
                     i        <= i_nxt;
                     j        <= '0;
                     done     <= 1'b0;
                     busy     <= 1'b1;
                     mem_en   <= 1'b1;
                     mem_addr <= addr_of(base_q, i_nxt, '0);
                     state    <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               mem_en <= 1'b0;
               if (RD_LAT == 1) begin
                  state <= CMP;
               end else begin
                  wcnt  <= '0;
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (wcnt == WCW'(RD_LAT - 2)) state <= CMP;
               else wcnt <= wcnt + WCW'(1);
            end
            CMP: begin
               if (hit && j == plen_ext - CW'(1)) begin
                  found      <= 1'b1;
                  match_addr <= addr_of(base_q, i, '0);
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  state      <= DONE;
               end else if (hit) begin
                  j        <= j_nxt;
                  mem_en   <= 1'b1;
                  mem_addr <= addr_of(base_q, i, j_nxt);
                  state    <= ISSUE;
               end else if (i < last_i) begin
                  i        <= i_nxt;
                  j        <= '0;
                  mem_en   <= 1'b1;
                  mem_addr <= addr_of(base_q, i_nxt, '0);
                  state    <= ISSUE;
               end else begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_psa_search_ctrl.sv
// Scoreboard bench for psa_search_ctrl: a software naive-search model predicts result,
// busy duration and BRAM read addresses for each start/resume.
module tb_psa_search_ctrl;
   typedef struct packed {
      logic        done;
      logic        found;
      logic        err;
      logic [7:0]  maddr;
      logic [15:0] busy;
   } res_t;
   typedef logic [7:0] addr_q_t[$];

   logic       clk;
   logic       reset;
   logic       start;
   logic       resume;
   logic [7:0] blk_base;
   logic [8:0] blk_len;
   logic [31:0] pattern;
   logic [2:0] pat_len;
   logic       mem_en;
   logic [7:0] mem_addr;
   logic [7:0] mem_rdata;
   logic       busy;
   logic       done;
   logic       found;
   logic [7:0] match_addr;
   logic       err;

   logic [7:0] mem [256];
   res_t       sb[$];
   addr_q_t    exp_addr;
   addr_q_t    obs_addr;
   int         npass = 0;
   int         ntotal = 0;
   logic [7:0] c_base;
   logic [31:0] c_pat;
   int         c_len;
   int         c_plen;
   int         m_i;

   psa_search_ctrl dut (
      .CLK100MHZ (clk),
      .reset     (reset),
      .start     (start),
      .resume    (resume),
      .blk_base  (blk_base),
      .blk_len   (blk_len),
      .pattern   (pattern),
      .pat_len   (pat_len),
      .mem_en    (mem_en),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .done      (done),
      .found     (found),
      .match_addr(match_addr),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];
   always @(negedge clk) if (mem_en === 1'b1) obs_addr.push_back(mem_addr);

   function automatic string fmt(input res_t r);
      return $sformatf("done=%0b found=%0b err=%0b addr=%0d busy_cycles=%0d",
                       r.done, r.found, r.err, r.maddr, r.busy);
   endfunction

   function automatic string qstr(input addr_q_t q);
      string s = "{";
      foreach (q[k]) s = {s, $sformatf(" %0d", q[k])};
      return {s, " }"};
   endfunction

   task automatic set_cfg(input logic [7:0] b, input int len, input logic [31:0] pat, input int plen);
      blk_base = b;
      blk_len  = 9'(len);
      pattern  = pat;
      pat_len  = 3'(plen);
      c_base = b;
      c_len  = len;
      c_pat  = pat;
      c_plen = plen;
      exp_addr.delete();
      obs_addr.delete();
   endtask

   // Independent naive search; each byte compare costs two busy cycles at RD_LAT=1.
   task automatic predict(input bit is_resume);
      res_t r;
      int i0;
      logic [7:0] a;
      r = '0;
      r.done = 1'b1;
      if (!is_resume && (c_plen == 0 || c_plen > 4 || c_plen > c_len)) begin
         r.err = 1'b1;
         sb.push_back(r);
         return;
      end
      i0 = is_resume ? m_i + 1 : 0;
      for (int i = i0; i <= c_len - c_plen && !r.found; i++) begin
         for (int j = 0; j < c_plen; j++) begin
            a = 8'(c_base + 8'(i) + 8'(j));
            exp_addr.push_back(a);
            r.busy = r.busy + 16'd2;
            if (mem[a] != c_pat[j*8 +: 8]) break;
            if (j == c_plen - 1) begin
               r.found = 1'b1;
               r.maddr = 8'(c_base + 8'(i));
               m_i = i;
            end
         end
      end
      sb.push_back(r);
   endtask

   task automatic pulse(input logic s, input logic r);
      @(negedge clk);
      start  = s;
      resume = r;
      @(negedge clk);
      start    = 1'b0;
      resume   = 1'b0;
      blk_base = 8'($urandom);
      blk_len  = 9'($urandom);
      pattern  = $urandom;
      pat_len  = 3'($urandom);
   endtask

   task automatic wait_done(output int bc, output bit tmo);
      bc  = 0;
      tmo = 1'b1;
      for (int k = 0; k < 2000; k++) begin
         if (done === 1'b1) begin
            tmo = 1'b0;
            break;
         end
         if (busy === 1'b1) bc++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      logic [20:0] o;
      reset  = 1'b0;
      start  = 1'b0;
      resume = 1'b0;
      set_cfg(8'd0, 10, 32'h0, 1);
      repeat (2) @(negedge clk);
      o = {busy, done, found, err, mem_en, mem_addr, match_addr};
      ntotal++;
      if (o === '0) npass++;
      else $display("[TB] FAIL reset_state: got %h expected 0", o);
      reset = 1'b1;
   endtask

   task automatic test_first_match();
      res_t e, o;
      int bc;
      bit tmo, same;
      set_cfg(8'd0, 10, 32'h0044_3322, 3);
      predict(1'b0);
      pulse(1'b1, 1'b0);
      wait_done(bc, tmo);
      o = {done, found, err, (found ? match_addr : 8'h00), 16'(bc)};
      e = sb.pop_front();
      ntotal++;
      if (!tmo && o === e) npass++;
      else $display("[TB] FAIL first_match: got %s expected %s", fmt(o), fmt(e));
      same = (obs_addr.size() == exp_addr.size());
      foreach (exp_addr[k]) if (same && obs_addr[k] !== exp_addr[k]) same = 1'b0;
      ntotal++;
      if (same) npass++;
      else $display("[TB] FAIL first_match_reads: got %s expected %s", qstr(obs_addr), qstr(exp_addr));
   endtask

   task automatic test_resume();
      res_t e, o;
      int bc;
      bit tmo, same;
      exp_addr.delete();
      obs_addr.delete();
      predict(1'b1);
      pulse(1'b0, 1'b1);
      wait_done(bc, tmo);
      o = {done, found, err, (found ? match_addr : 8'h00), 16'(bc)};
      e = sb.pop_front();
      ntotal++;
      if (!tmo && o === e) npass++;
      else $display("[TB] FAIL resume_next: got %s expected %s", fmt(o), fmt(e));
      same = (obs_addr.size() == exp_addr.size());
      foreach (exp_addr[k]) if (same && obs_addr[k] !== exp_addr[k]) same = 1'b0;
      ntotal++;
      if (same) npass++;
      else $display("[TB] FAIL resume_reads: got %s expected %s", qstr(obs_addr), qstr(exp_addr));
   endtask

   task automatic test_resume_last();
      res_t e, o;
      int bc;
      bit tmo;
      exp_addr.delete();
      obs_addr.delete();
      predict(1'b1);
      pulse(1'b0, 1'b1);
      wait_done(bc, tmo);
      o = {done, found, err, (found ? match_addr : 8'h00), 16'(bc)};
      e = sb.pop_front();
      ntotal++;
      if (!tmo && o === e) npass++;
      else $display("[TB] FAIL resume_last: got %s expected %s", fmt(o), fmt(e));
      ntotal++;
      if (obs_addr.size() == 1 && obs_addr[0] === 8'd7) npass++;
      else $display("[TB] FAIL resume_last_reads: got %s expected { 7 }", qstr(obs_addr));
      // A resume after an unsuccessful search must leave everything untouched.
      obs_addr.delete();
      pulse(1'b0, 1'b1);
      bc = 0;
      repeat (3) begin
         if (busy !== 1'b0) bc++;
         @(negedge clk);
      end
      o = {done, found, err, 8'h00, 16'(bc)};
      e = '0;
      e.done = 1'b1;
      ntotal++;
      if (o === e) npass++;
      else $display("[TB] FAIL resume_ignored: got %s expected %s", fmt(o), fmt(e));
      ntotal++;
      if (obs_addr.size() == 0) npass++;
      else $display("[TB] FAIL resume_ignored_reads: got %s expected { }", qstr(obs_addr));
   endtask

   task automatic test_resume_past_end();
      res_t e, o;
      int bc;
      bit tmo, same;
      set_cfg(8'd4, 2, 32'h0000_4433, 2);
      predict(1'b0);
      pulse(1'b1, 1'b0);
      wait_done(bc, tmo);
      o = {done, found, err, (found ? match_addr : 8'h00), 16'(bc)};
      e = sb.pop_front();
      ntotal++;
      if (!tmo && o === e) npass++;
      else $display("[TB] FAIL single_window: got %s expected %s", fmt(o), fmt(e));
      predict(1'b1);
      pulse(1'b0, 1'b1);
      wait_done(bc, tmo);
      o = {done, found, err, (found ? match_addr : 8'h00), 16'(bc)};
      e = sb.pop_front();
      ntotal++;
      if (!tmo && o === e) npass++;
      else $display("[TB] FAIL resume_past_end: got %s expected %s", fmt(o), fmt(e));
      same = (obs_addr.size() == exp_addr.size());
      foreach (exp_addr[k]) if (same && obs_addr[k] !== exp_addr[k]) same = 1'b0;
      ntotal++;
      if (same) npass++;
      else $display("[TB] FAIL resume_past_end_reads: got %s expected %s", qstr(obs_addr), qstr(exp_addr));
   endtask

   task automatic test_wrap();
      res_t e, o;
      int bc;
      bit tmo, same;
      set_cfg(8'd254, 4, 32'h0000_11AA, 2);
      predict(1'b0);
      pulse(1'b1, 1'b0);
      wait_done(bc, tmo);
      o = {done, found, err, (found ? match_addr : 8'h00), 16'(bc)};
      e = sb.pop_front();
      ntotal++;
      if (!tmo && o === e) npass++;
      else $display("[TB] FAIL wrap_match: got %s expected %s", fmt(o), fmt(e));
      same = (obs_addr.size() == exp_addr.size());
      foreach (exp_addr[k]) if (same && obs_addr[k] !== exp_addr[k]) same = 1'b0;
      ntotal++;
      if (same) npass++;
      else $display("[TB] FAIL wrap_reads: got %s expected %s", qstr(obs_addr), qstr(exp_addr));
   endtask

   task automatic test_bad_config();
      res_t e, o;
      for (int n = 0; n < 2; n++) begin
         if (n == 0) set_cfg(8'd0, 10, 32'h0044_3322, 0);
         else        set_cfg(8'd0, 3, 32'h5544_3322, 4);
         predict(1'b0);
         pulse(1'b1, 1'b0);
         o = {done, found, err, (found ? match_addr : 8'h00), 16'(busy)};
         e = sb.pop_front();
         ntotal++;
         if (o === e) npass++;
         else $display("[TB] FAIL bad_config_%0d: got %s expected %s", n, fmt(o), fmt(e));
         repeat (3) @(negedge clk);
         ntotal++;
         if (obs_addr.size() == 0 && err === 1'b1) npass++;
         else $display("[TB] FAIL bad_config_reads_%0d: got %s err=%0b expected { } err=1", n, qstr(obs_addr), err);
      end
   endtask

   task automatic test_reset_abort();
      res_t e, o;
      int bc;
      bit tmo, same;
      logic [4:0] flags;
      set_cfg(8'd0, 10, 32'h0044_3322, 3);
      pulse(1'b1, 1'b0);
      repeat (5) @(negedge clk);
      #2 reset = 1'b0;
      #1 flags = {busy, done, found, err, mem_en};
      ntotal++;
      if (flags === 5'b0) npass++;
      else $display("[TB] FAIL async_abort: got busy/done/found/err/mem_en=%b expected 00000", flags);
      @(negedge clk);
      reset = 1'b1;
      set_cfg(8'd0, 10, 32'h0044_3322, 3);
      predict(1'b0);
      pulse(1'b1, 1'b0);
      wait_done(bc, tmo);
      o = {done, found, err, (found ? match_addr : 8'h00), 16'(bc)};
      e = sb.pop_front();
      ntotal++;
      if (!tmo && o === e) npass++;
      else $display("[TB] FAIL rerun_after_reset: got %s expected %s", fmt(o), fmt(e));
      same = (obs_addr.size() == exp_addr.size());
      foreach (exp_addr[k]) if (same && obs_addr[k] !== exp_addr[k]) same = 1'b0;
      ntotal++;
      if (same) npass++;
      else $display("[TB] FAIL rerun_reads: got %s expected %s", qstr(obs_addr), qstr(exp_addr));
   endtask

   initial begin
      foreach (mem[k]) mem[k] = 8'h00;
      mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h22; mem[4] = 8'h33;
      mem[5] = 8'h44; mem[6] = 8'h22; mem[7] = 8'h33; mem[8] = 8'h44; mem[9] = 8'h55;
      mem[254] = 8'h01;
      mem[255] = 8'hAA;
      test_reset();
      test_first_match();
      test_resume();
      test_resume_last();
      test_resume_past_end();
      test_wrap();
      test_bad_config();
      test_reset_abort();
      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: still running at %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
